tank_motion_ctrl: RTL
=====================

# tank_motion_ctrl

Sequences the player tank's position registers and the shared bullet resource. Takes debounced direction/fire levels from the keyboard decoder and produces the sprite `pos_x`/`pos_y` and facing `direction` for the sprite renderer, plus a single-cycle bullet launch request. Moves are paced by an internal tick, turns are separated from moves, positions are clamped to the playfield, and fire is rate-limited and gated by bullet availability.

## Interface
- `SPEED`, 1: pixels moved per move tick.
- `TICK_DIV`, 50000: `clk` cycles per move tick (1 kHz at 50 MHz).
- `X_INIT`, 250 / `Y_INIT`, 150: position after reset.
- `X_MAX`, 608 / `Y_MAX`, 448: inclusive upper clamp (640−32, 480−32). The lower clamp is 0.
- `FIRE_COOLDOWN`, 250: move ticks between accepted shots.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  reset. Synchronous and active-high (name the clock and reset ports as the codebase does; the polarity and synchronicity here are fixed).
- `up`, `down`, `left`, `right`  in  1 each  key-held levels, already synchronous to `clk`.
- `fire`  in  1  fire key level.
- `bullet_busy`  in  1  the single player bullet is in flight.
- `pos_x`, `pos_y`  out  10 each  tank top-left pixel.
- `direction`  out  2  facing: 0 up, 1 down, 2 left, 3 right.
- `moving`  out  1  high while in state MOVE.
- `fire_pulse`  out  1  one-cycle bullet launch request.

## Operation
- **Tick generation.** The tick counter counts 0…TICK_DIV−1. `tick` is high for the one cycle where count = TICK_DIV−1, then the counter wraps to 0.
- **Key priority.** up > down > left > right. `req_valid` is high when any direction key is held. `req_dir` is the highest-priority held key.
- **FSM states:** IDLE, TURN, MOVE. The FSM is evaluated only on `tick` cycles.
- **IDLE:**
  - `req_valid` and `req_dir` ≠ `direction` → TURN: `direction` ← `req_dir`, no position change.
  - `req_valid` and `req_dir` = `direction` → MOVE, and this tick applies a step.
- **TURN:**
  - `req_valid` and `req_dir` = `direction` → MOVE with a step.
  - `req_valid` with a different `req_dir` → stay in TURN and re-turn.
  - no key → IDLE.
- **MOVE:**
  - Same `req_dir` → step and stay in MOVE.
  - Different `req_dir` → TURN; `direction` updates and no step is taken.
  - No key → IDLE.
- **Step arithmetic.** Computed in 11-bit signed.
  - Up: `pos_y` ← max(`pos_y` − SPEED, 0).
  - Down: `pos_y` ← min(`pos_y` + SPEED, Y_MAX).
  - Left and right: the same rule on `pos_x`, with X_MAX as the upper clamp.
  - No wrap-around is ever permitted.
  - When a step is fully blocked by a clamp, the FSM stays in MOVE with position unchanged.
- **Fire edge detection.** `fire_d` registers `fire`. `fire_edge` = `fire` & ~`fire_d`. Held fire does not auto-repeat.
- **Fire acceptance.** On `fire_edge`, if cooldown = 0 and `bullet_busy` = 0: `fire_pulse` goes high for the next cycle and cooldown is loaded with FIRE_COOLDOWN.
- **Fire rejection.** Otherwise the edge is dropped and not queued.
- **Cooldown.** Decrements by 1 on each `tick` while nonzero.
- **Simultaneous events.** Fire is independent of the FSM; a fire edge on a tick cycle is handled in parallel with the move.

## Timing
- **Reset values** (registered, synchronous):
  - `pos_x` = X_INIT, `pos_y` = Y_INIT, `direction` = 0.
  - `moving` = 0, `fire_pulse` = 0.
  - FSM = IDLE; tick counter, cooldown and `fire_d` = 0.
- **Reset mid-operation.** Reset asserted mid-move or mid-cooldown restores all of the above on the next edge. A pending fire edge is lost.
- **Outputs.** All outputs are registered.
- **Move latency.** Position, direction and `moving` change on the clock edge ending the `tick` cycle and are visible in the following cycle.
- **Fire latency.** `fire` rising sampled in cycle N gives `fire_pulse` = 1 in cycle N+1 only.
- **Keys.** Sampled only on `tick` cycles; keys toggled between ticks are ignored.

## Structure
- **Shared package** `tank_pkg` holds:
  - the direction encoding constants DIR_UP/DIR_DOWN/DIR_LEFT/DIR_RIGHT;
  - the FSM state typedef;
  - the screen constants 640/480/32 from which X_MAX and Y_MAX derive.
- **Sub-module** `tick_gen` (parameter DIV; ports `clk`, `rst`, `tick`) holds the tick counter. It is reusable for enemy tanks and bullets.
- **Reset fan-out.** The position registers are the only datapath here. The sprite renderer consumes `pos_x`, `pos_y` and `direction` directly.

## Test plan
All directed tests run with TICK_DIV = 4, FIRE_COOLDOWN = 3, SPEED = 1.
- **Reset:** assert `rst` for 2 cycles → `pos` = (250,150), `direction` = 0, `moving` = 0, `fire_pulse` = 0.
- **Turn then move:** hold `right` for 3 ticks →
  - tick 1: `direction` = 3, pos unchanged;
  - ticks 2–3: `pos_x` = 251 then 252, `moving` = 1;
  - release → `moving` = 0 after the next tick.
- **Priority:** from facing up, hold `up` + `left` 2 ticks → `pos_y` 150→149→148, `pos_x` stays 250.
- **Clamp:** preload by moving to `pos_y` = 0, hold `up` 3 more ticks → `pos_y` stays 0, `moving` = 1, no wrap to 1023. Repeat at `pos_x` = 608 with `right`.
- **Fire gating:**
  - fire edge with cooldown 0, `bullet_busy` = 0 → exactly one `fire_pulse`, 1 cycle after the edge;
  - a second edge within 3 ticks → no pulse;
  - an edge after 3 ticks with `bullet_busy` = 1 → no pulse;
  - with `bullet_busy` = 0 → pulse.
- **Reset mid-operation:** assert `rst` during MOVE with cooldown = 2 → position returns to (250,150), and an immediate fire edge after reset is accepted.

Source files
------------

// File: rtl/tank_pkg.sv
// Shared constants and types for the tank game: direction encoding, motion FSM states and
// playfield geometry.
package tank_pkg;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam int unsigned SCREEN_W  = 640;
   localparam int unsigned SCREEN_H  = 480;
   localparam int unsigned TANK_SIZE = 32;

   // Inclusive top-left clamp so the whole sprite stays on screen.
   localparam int unsigned X_MAX_DEFAULT = SCREEN_W - TANK_SIZE;
   localparam int unsigned Y_MAX_DEFAULT = SCREEN_H - TANK_SIZE;

   typedef enum logic [1:0] {
      StIdle,
      StTurn,
      StMove
   } motion_state_e;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: tick is high for one clk cycle out of every DIV.
module tick_gen #(
   parameter int unsigned DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;

   assign tick = (cnt_q == CntW'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      if (tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tank_motion_ctrl.sv
// Player tank motion sequencer: tick-paced turn/move FSM with clamped position and a
// rate-limited, bullet-gated fire pulse.
module tank_motion_ctrl
   import tank_pkg::*;
#(
   parameter int unsigned SPEED         = 1,
   parameter int unsigned TICK_DIV      = 50000,
   parameter int unsigned X_INIT        = 250,
   parameter int unsigned Y_INIT        = 150,
   parameter int unsigned X_MAX         = X_MAX_DEFAULT,
   parameter int unsigned Y_MAX         = Y_MAX_DEFAULT,
   parameter int unsigned FIRE_COOLDOWN = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       up,
   input  logic       down,
   input  logic       left,
   input  logic       right,
   input  logic       fire,
   input  logic       bullet_busy,
   output logic [9:0] pos_x,
   output logic [9:0] pos_y,
   output logic [1:0] direction,
   output logic       moving,
   output logic       fire_pulse
);

   localparam int unsigned CdW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;

   logic tick;

   tick_gen #(
      .DIV(TICK_DIV)
   ) u_tick_gen (
      .clk (clk),
      .rst (rst),
      .tick(tick)
   );

   // Signed 11-bit step so an underflow below zero is visible before clamping.
   function automatic logic [9:0] clamp_step(input logic [9:0] pos, input logic dec,
                                             input logic [9:0] max_pos);
      logic signed [10:0] sum;
      if (dec) begin
         sum = $signed({1'b0, pos}) - $signed(11'(SPEED));
      end else begin
         sum = $signed({1'b0, pos}) + $signed(11'(SPEED));
      end
      if (sum < 11'sd0) begin
         return 10'd0;
      end
      if (sum > $signed({1'b0, max_pos})) begin
         return max_pos;
      end
      return sum[9:0];
   endfunction

   logic          req_valid;
   logic [1:0]    req_dir;
   motion_state_e state_q, state_d;
   logic [9:0]    pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [9:0]    step_x, step_y;
   logic [1:0]    dir_q, dir_d;
   logic          moving_q, moving_d;
   logic          fire_d_q, fire_edge, fire_accept;
   logic          fire_pulse_q;
   logic [CdW-1:0] cooldown_q, cooldown_d;

   always_comb begin
      req_valid = up | down | left | right;
      req_dir   = DIR_RIGHT;
      if (up) begin
         req_dir = DIR_UP;
      end else if (down) begin
         req_dir = DIR_DOWN;
      end else if (left) begin
         req_dir = DIR_LEFT;
      end
   end

   always_comb begin
      step_x = pos_x_q;
      step_y = pos_y_q;
      unique case (req_dir)
         DIR_UP:    step_y = clamp_step(pos_y_q, 1'b1, 10'(Y_MAX));
         DIR_DOWN:  step_y = clamp_step(pos_y_q, 1'b0, 10'(Y_MAX));
         DIR_LEFT:  step_x = clamp_step(pos_x_q, 1'b1, 10'(X_MAX));
         DIR_RIGHT: step_x = clamp_step(pos_x_q, 1'b0, 10'(X_MAX));
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Every state applies the same rule; a clamped step still counts as a move.
   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      if (tick) begin
         unique case (state_q)
            StIdle, StTurn, StMove: begin
               if (!req_valid) begin
                  state_d = StIdle;
               end else if (req_dir != dir_q) begin
                  state_d = StTurn;
                  dir_d   = req_dir;
               end else begin
                  state_d = StMove;
                  pos_x_d = step_x;
                  pos_y_d = step_y;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_comb begin
      moving_d = (state_d == StMove);
   end

   assign fire_edge   = fire & ~fire_d_q;
   assign fire_accept = fire_edge & (cooldown_q == '0) & ~bullet_busy;

   always_comb begin
      cooldown_d = cooldown_q;
      if (fire_accept) begin
         cooldown_d = CdW'(FIRE_COOLDOWN);
      end else if (tick && (cooldown_q != '0)) begin
         cooldown_d = cooldown_q - CdW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_x_q      <= 10'(X_INIT);
         pos_y_q      <= 10'(Y_INIT);
         dir_q        <= DIR_UP;
         moving_q     <= 1'b0;
         fire_d_q     <= 1'b0;
         fire_pulse_q <= 1'b0;
         cooldown_q   <= '0;
      end else begin
         pos_x_q      <= pos_x_d;
         pos_y_q      <= pos_y_d;
         dir_q        <= dir_d;
         moving_q     <= moving_d;
         fire_d_q     <= fire;
         fire_pulse_q <= fire_accept;
         cooldown_q   <= cooldown_d;
      end
   end

   assign pos_x      = pos_x_q;
   assign pos_y      = pos_y_q;
   assign direction  = dir_q;
   assign moving     = moving_q;
   assign fire_pulse = fire_pulse_q;

endmodule
